// File: rtl/tiny_rv_decode_if.sv
// tiny_rv_decode_if: fetch, writeback and ID/EX signals of the tiny_rv decode stage
interface tiny_rv_decode_if;
  logic [31:0] i_fetched_pc;
  logic [31:0] i_fetched_inst;
  logic        i_pipe_stall;
  logic        i_pipe_flush;
  logic        i_wb_en;
  logic [4:0]  i_wb_rd;
  logic [31:0] i_wb_data;
  logic        o_stall_req;
  logic        o_valid;
  logic [31:0] o_pc;
  logic [31:0] o_rs1_data;
  logic [31:0] o_rs2_data;
  logic [31:0] o_imm;
  logic [4:0]  o_rs1;
  logic [4:0]  o_rs2;
  logic [4:0]  o_rd;
  logic [2:0]  o_funct3;
  logic [3:0]  o_alu_op;
  logic        o_alu_src_imm;
  logic        o_alu_src_pc;
  logic        o_reg_write;
  logic        o_is_load;
  logic        o_is_store;
  logic        o_is_branch;
  logic        o_is_jal;
  logic        o_is_jalr;
  logic        o_illegal;
  modport master (
    output i_fetched_pc, i_fetched_inst, i_pipe_stall, i_pipe_flush, i_wb_en, i_wb_rd, i_wb_data,
    input  o_stall_req, o_valid, o_pc, o_rs1_data, o_rs2_data, o_imm, o_rs1, o_rs2, o_rd,
           o_funct3, o_alu_op, o_alu_src_imm, o_alu_src_pc, o_reg_write, o_is_load,
           o_is_store, o_is_branch, o_is_jal, o_is_jalr, o_illegal
  );
  modport slave (
    input  i_fetched_pc, i_fetched_inst, i_pipe_stall, i_pipe_flush, i_wb_en, i_wb_rd, i_wb_data,
    output o_stall_req, o_valid, o_pc, o_rs1_data, o_rs2_data, o_imm, o_rs1, o_rs2, o_rd,
           o_funct3, o_alu_op, o_alu_src_imm, o_alu_src_pc, o_reg_write, o_is_load,
           o_is_store, o_is_branch, o_is_jal, o_is_jalr, o_illegal
  );
endinterface

// File: rtl/tiny_rv_decode.sv
// tiny_rv_decode: RV32I decode, register file read and ID/EX register with load-use stall
module tiny_rv_decode #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input logic            i_clk,
  input logic            i_reset_n,
  tiny_rv_decode_if.slave bus
);
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [3:0]  alu_op;
    logic        alu_src_imm;
    logic        alu_src_pc;
    logic        reg_write;
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic        illegal;
  } idex_t;
  localparam idex_t IDEX_RST = '{pc: RESET_PC, default: '0};
  logic [31:0] rf_q [32];
  logic [31:0] rf_d [32];
  idex_t       idex_q, idex_d, dec;
  logic [31:0] inst;
  logic [6:0]  opc;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  f3;
  logic        op, op_imm, lui, auipc, load, store, branch, jal, jalr, known;
  logic        uses_rs1, uses_rs2, stall_req;
  logic [3:0]  alu_f;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign inst   = bus.i_fetched_inst;
  assign opc    = inst[6:0];
  assign rd     = inst[11:7];
  assign f3     = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign op     = opc == 7'b0110011;
  assign op_imm = opc == 7'b0010011;
  assign lui    = opc == 7'b0110111;
  assign auipc  = opc == 7'b0010111;
  assign load   = opc == 7'b0000011;
  assign store  = opc == 7'b0100011;
  assign branch = opc == 7'b1100011;
  assign jal    = opc == 7'b1101111;
  assign jalr   = opc == 7'b1100111;
  assign known  = op | op_imm | lui | auipc | load | store | branch | jal | jalr;
  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u  = {inst[31:12], 12'b0};
  assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  // Only register-register ADD may become SUB; ADDI ignores bit 30
  assign alu_f  = f3 == 3'd0 ? ((op & inst[30]) ? 4'd1 : 4'd0) :
                  f3 == 3'd1 ? 4'd2 : f3 == 3'd2 ? 4'd3 : f3 == 3'd3 ? 4'd4 :
                  f3 == 3'd4 ? 4'd5 : f3 == 3'd5 ? (inst[30] ? 4'd7 : 4'd6) :
                  f3 == 3'd6 ? 4'd8 : 4'd9;
  assign uses_rs1  = !(lui | auipc | jal);
  assign uses_rs2  = op | store | branch;
  assign stall_req = idex_q.valid & idex_q.is_load & (idex_q.rd != 5'd0) &
                     ((uses_rs1 & (idex_q.rd == rs1)) | (uses_rs2 & (idex_q.rd == rs2)));
  always_comb begin
    dec             = '0;
    dec.valid       = 1'b1;
    dec.pc          = bus.i_fetched_pc;
    dec.rs1         = rs1;
    dec.rs2         = rs2;
    dec.rd          = rd;
    dec.funct3      = f3;
    dec.rs1_data    = rs1 == 5'd0 ? 32'h0 : (bus.i_wb_en && bus.i_wb_rd == rs1) ? bus.i_wb_data : rf_q[rs1];
    dec.rs2_data    = rs2 == 5'd0 ? 32'h0 : (bus.i_wb_en && bus.i_wb_rd == rs2) ? bus.i_wb_data : rf_q[rs2];
    dec.imm         = (op_imm | load | jalr) ? imm_i : store ? imm_s : branch ? imm_b :
                      (lui | auipc) ? imm_u : jal ? imm_j : 32'h0;
    dec.alu_op      = (op | op_imm) ? alu_f : lui ? 4'd10 : branch ? 4'd1 : 4'd0;
    dec.alu_src_imm = op_imm | lui | auipc | load | store | jal | jalr;
    dec.alu_src_pc  = auipc | jal;
    dec.reg_write   = (op | op_imm | lui | auipc | load | jal | jalr) & (rd != 5'd0);
    dec.is_load     = load;
    dec.is_store    = store;
    dec.is_branch   = branch;
    dec.is_jal      = jal;
    dec.is_jalr     = jalr;
    dec.illegal     = !known;
  end
  always_comb begin
    idex_d = bus.i_pipe_flush ? '0 : bus.i_pipe_stall ? idex_q :
             (stall_req || inst == 32'h0) ? '0 : dec;
    rf_d = rf_q;
    if (bus.i_wb_en && bus.i_wb_rd != 5'd0) rf_d[bus.i_wb_rd] = bus.i_wb_data;
  end
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      idex_q <= IDEX_RST;
      rf_q   <= '{default: '0};
    end else begin
      idex_q <= idex_d;
      rf_q   <= rf_d;
    end
  assign bus.o_stall_req   = stall_req;
  assign bus.o_valid       = idex_q.valid;
  assign bus.o_pc          = idex_q.pc;
  assign bus.o_rs1_data    = idex_q.rs1_data;
  assign bus.o_rs2_data    = idex_q.rs2_data;
  assign bus.o_imm         = idex_q.imm;
  assign bus.o_rs1         = idex_q.rs1;
  assign bus.o_rs2         = idex_q.rs2;
  assign bus.o_rd          = idex_q.rd;
  assign bus.o_funct3      = idex_q.funct3;
  assign bus.o_alu_op      = idex_q.alu_op;
  assign bus.o_alu_src_imm = idex_q.alu_src_imm;
  assign bus.o_alu_src_pc  = idex_q.alu_src_pc;
  assign bus.o_reg_write   = idex_q.reg_write;
  assign bus.o_is_load     = idex_q.is_load;
  assign bus.o_is_store    = idex_q.is_store;
  assign bus.o_is_branch   = idex_q.is_branch;
  assign bus.o_is_jal      = idex_q.is_jal;
  assign bus.o_is_jalr     = idex_q.is_jalr;
  assign bus.o_illegal     = idex_q.illegal;
endmodule
